mioc_dram_seq: RTL

// - DRAM cycle sequencer and DMA bus arbiter for the MIOC. Sits between the buffered Z80 strobes and the DRAM array.
// - Generates RAS_N/MUX/CAS1_N/CAS2_N for CPU reads/writes, RAS-only refresh and 6801 DMA accesses.
// - Owns the BUSRQ_N/BUSAK_N handshake that hands the memory bus to the master 6801 (grant on IS3_N).

---
 rtl/mioc_dram_seq.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mioc_dram_seq.sv
// DRAM cycle sequencer (RAS/MUX/CAS timing, refresh) and 6801 DMA bus arbiter for the MIOC.
// Optional opcode-fetch wait state is built when MIOC_DRAM_WAIT_EN is defined.
module mioc_dram_seq #(
  parameter int unsigned RAS_TO_MUX = 1,
  parameter int unsigned MUX_TO_CAS = 1,
  parameter int unsigned CAS_WIDTH  = 2,
  parameter int unsigned PRECHARGE  = 1
) (
  input  logic B_PHI,
  input  logic RST_N,
  input  logic BMREQ_N,
  input  logic BRD_N,
  input  logic N_BWR,
  input  logic BRFSH_N,
  input  logic BM1_N,
  input  logic BA15,
  input  logic DMA_N,
  input  logic BUSAK_N,
  output logic BUSRQ_N,
  output logic ADDRBUFEN_N,
  output logic IS3_N,
  output logic RAS_N,
  output logic MUX,
  output logic CAS1_N,
  output logic CAS2_N,
  output logic MWAIT_N
);

  localparam logic [2:0] LdRas = 3'(RAS_TO_MUX - 1);
  localparam logic [2:0] LdMux = 3'(MUX_TO_CAS - 1);
  localparam logic [2:0] LdCas = 3'(CAS_WIDTH - 1);
  localparam logic [2:0] LdPre = 3'(PRECHARGE - 1);

  typedef enum logic [2:0] {SeqIdle, SeqRas, SeqMux, SeqCas, SeqPre} seq_e;
  typedef enum logic [2:0] {ArbIdle, ArbReq, ArbGnt, ArbDrain, ArbRel} arb_e;

  seq_e       seq_q, seq_d;
  arb_e       arb_q, arb_d;
  logic [2:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       rfsh_q, rfsh_d;
  logic       bank_q, bank_d;
  logic       start;

  logic ras_n_q, ras_n_d;
  logic mux_q, mux_d;
  logic cas1_n_q, cas1_n_d;
  logic cas2_n_q, cas2_n_d;
  logic busrq_n_q, busrq_n_d;
  logic abe_n_q, abe_n_d;
  logic is3_n_q, is3_n_d;
  logic mwait_n_d;
  logic mwait_n_q;

  // State register
  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) begin
      seq_q     <= SeqIdle;
      arb_q     <= ArbIdle;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
      rfsh_q    <= 1'b0;
      bank_q    <= 1'b0;
      ras_n_q   <= 1'b1;
      mux_q     <= 1'b0;
      cas1_n_q  <= 1'b1;
      cas2_n_q  <= 1'b1;
      busrq_n_q <= 1'b1;
      abe_n_q   <= 1'b0;
      is3_n_q   <= 1'b1;
      mwait_n_q <= 1'b1;
    end else begin
      seq_q     <= seq_d;
      arb_q     <= arb_d;
      cnt_q     <= cnt_d;
      armed_q   <= armed_d;
      rfsh_q    <= rfsh_d;
      bank_q    <= bank_d;
      ras_n_q   <= ras_n_d;
      mux_q     <= mux_d;
      cas1_n_q  <= cas1_n_d;
      cas2_n_q  <= cas2_n_d;
      busrq_n_q <= busrq_n_d;
      abe_n_q   <= abe_n_d;
      is3_n_q   <= is3_n_d;
      mwait_n_q <= mwait_n_d;
    end
  end

  // Sequencer next state; refresh walks the same states with MUX/CAS suppressed
  always_comb begin
    seq_d   = seq_q;
    cnt_d   = cnt_q;
    armed_d = armed_q | BMREQ_N;
    rfsh_d  = rfsh_q;
    bank_d  = bank_q;
    start   = 1'b0;
    unique case (seq_q)
      SeqIdle: begin
        if (armed_q && !BMREQ_N && (!BRFSH_N || !BRD_N || !N_BWR)) begin
          start   = 1'b1;
          seq_d   = SeqRas;
          cnt_d   = LdRas;
          armed_d = 1'b0;
          rfsh_d  = !BRFSH_N;
          bank_d  = BA15;
        end
      end
      SeqRas: begin
        if (cnt_q == 3'd0) begin
          seq_d = SeqMux;
          cnt_d = LdMux;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      SeqMux: begin
        if (cnt_q == 3'd0) begin
          seq_d = SeqCas;
          cnt_d = LdCas;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      SeqCas: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else if (rfsh_q || BMREQ_N) begin
          seq_d = SeqPre;
          cnt_d = LdPre;
        end
      end
      SeqPre: begin
        if (cnt_q == 3'd0) begin
          seq_d = SeqIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: seq_d = SeqIdle;
    endcase
  end

  // Arbiter next state; bus ownership only changes while the sequencer is idle
  always_comb begin
    arb_d = arb_q;
    unique case (arb_q)
      ArbIdle:  if (!DMA_N) arb_d = ArbReq;
      ArbReq:   if (!BUSAK_N && seq_d == SeqIdle) arb_d = ArbGnt;
      ArbGnt:   if (DMA_N) arb_d = (seq_d == SeqIdle) ? ArbRel : ArbDrain;
      ArbDrain: if (seq_d == SeqIdle) arb_d = ArbRel;
      ArbRel:   if (BUSAK_N) arb_d = ArbIdle;
      default:  arb_d = ArbIdle;
    endcase
  end

  // Registered outputs decoded from next state
  always_comb begin
    ras_n_d   = !(seq_d inside {SeqRas, SeqMux, SeqCas});
    mux_d     = (seq_d inside {SeqMux, SeqCas}) && !rfsh_d;
    cas1_n_d  = !(seq_d == SeqCas && !rfsh_d && !bank_d);
    cas2_n_d  = !(seq_d == SeqCas && !rfsh_d && bank_d);
    busrq_n_d = arb_d inside {ArbIdle, ArbRel};
    abe_n_d   = arb_d inside {ArbGnt, ArbDrain};
    is3_n_d   = (arb_d != ArbGnt);
  end

`ifdef MIOC_DRAM_WAIT_EN
  logic wait_q, wait_d;

  // Only CPU opcode fetches wait; DMA and refresh cycles never do
  always_comb begin
    wait_d = wait_q;
    if (start) wait_d = !BM1_N && BRFSH_N && !(arb_q inside {ArbGnt, ArbDrain});
    mwait_n_d = !(wait_d && (seq_d inside {SeqRas, SeqMux}));
  end

  always_ff @(posedge B_PHI or negedge RST_N) begin
    if (!RST_N) wait_q <= 1'b0;
    else        wait_q <= wait_d;
  end
`else
  logic unused_bm1_n;
  assign unused_bm1_n = BM1_N;
  assign mwait_n_d    = 1'b1;
`endif

  assign RAS_N       = ras_n_q;
  assign MUX         = mux_q;
  assign CAS1_N      = cas1_n_q;
  assign CAS2_N      = cas2_n_q;
  assign BUSRQ_N     = busrq_n_q;
  assign ADDRBUFEN_N = abe_n_q;
  assign IS3_N       = is3_n_q;
  assign MWAIT_N     = mwait_n_q;

endmodule
